// File: rtl/uart_pkg.sv
// uart_pkg: types and constants shared by the UART blocks.
//   tx_state_t           - transmitter FSM state encoding
//   DEFAULT_CLKS_PER_BIT - 25 MHz / 115200 baud
//   even_parity()        - XOR reduction of a word (zero-extended to 32 bits)
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        START  = 3'd2,
        DATA   = 3'd3,
        PARITY = 3'd4,
        STOP   = 3'd5
    } tx_state_t;

    localparam int DEFAULT_CLKS_PER_BIT = 217;

    // Callers zero-extend their word; extra zero bits do not change the XOR.
    function automatic logic even_parity(input logic [31:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// uart_bit_timer: baud counter shared by the UART transmitter and receiver.
// Counts 0..CLKS_PER_BIT-1 and returns to 0 after the terminal count.
//   clk   - system clock
//   rst   - synchronous active-high reset
//   clear - hold the counter at 0 while the owner is not timing a bit
//   tick  - high during the terminal-count cycle (last cycle of a bit)
//   count - current position within the bit
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 217,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic             tick,
    output logic [CNT_W-1:0] count
);

    assign tick = (count == CNT_W'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst || clear || tick) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: UART transmitter draining a synchronous FIFO.
// Pops one word per frame and sends it 8N1, LSB first. Defining
// UART_TX_PARITY_EN inserts an even-parity bit between data and stop (8E1).
//   clk_i       - system clock
//   rst_i       - synchronous active-high reset
//   empty_i     - FIFO empty flag
//   rd_en_o     - one-cycle FIFO pop strobe, at most one per frame
//   rd_dv_i     - FIFO read-data-valid, only looked at in FETCH
//   rd_data_i   - FIFO read data
//   tx_serial_o - UART line, idles high
//   tx_active_o - high from START through STOP
//   tx_done_o   - one-cycle pulse on the last stop-bit cycle
// All outputs are registered. WIDTH is limited to 32 by the parity helper.
//
// state  | meaning
// IDLE   | line high, pop a word as soon as the FIFO is non-empty
// FETCH  | pop issued, waiting for rd_dv_i (no timeout)
// START  | start bit (0)
// DATA   | WIDTH data bits, LSB first
// PARITY | even-parity bit (UART_TX_PARITY_EN only)
// STOP   | stop bit (1), tx_done_o on its last cycle
module fifo_uart_tx
    import uart_pkg::*;
#(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             empty_i,
    output logic             rd_en_o,
    input  logic             rd_dv_i,
    input  logic [WIDTH-1:0] rd_data_i,
    output logic             tx_serial_o,
    output logic             tx_active_o,
    output logic             tx_done_o
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(WIDTH);

    tx_state_t        state;
    logic [WIDTH-1:0] shift_reg;
    logic [IDX_W-1:0] bit_idx;
    logic             timer_clear;
    logic             bit_tick;
    logic [CNT_W-1:0] baud_count;
    logic             done_next;
`ifdef UART_TX_PARITY_EN
    logic             parity_bit;
`endif

    // Timer sits at 0 outside the frame so START always gets a full bit.
    assign timer_clear = (state == IDLE) || (state == FETCH);

    // tx_done_o is registered, so it is set one cycle before the last stop cycle.
    assign done_next = (state == STOP) && (baud_count == CNT_W'(CLKS_PER_BIT - 2));

    uart_bit_timer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .CNT_W        (CNT_W)
    ) u_bit_timer (
        .clk   (clk_i),
        .rst   (rst_i),
        .clear (timer_clear),
        .tick  (bit_tick),
        .count (baud_count)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= IDLE;
            shift_reg   <= '0;
            bit_idx     <= '0;
            rd_en_o     <= 1'b0;
            tx_serial_o <= 1'b1;
            tx_active_o <= 1'b0;
            tx_done_o   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit  <= 1'b0;
`endif
        end else begin
            rd_en_o   <= 1'b0;
            tx_done_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (!empty_i) begin
                        rd_en_o <= 1'b1;
                        state   <= FETCH;
                    end
                end
                FETCH: begin
                    if (rd_dv_i) begin
                        shift_reg   <= rd_data_i;
                        bit_idx     <= '0;
`ifdef UART_TX_PARITY_EN
                        parity_bit  <= even_parity(32'(rd_data_i));
`endif
                        tx_serial_o <= 1'b0;
                        tx_active_o <= 1'b1;
                        state       <= START;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        tx_serial_o <= shift_reg[0];
                        shift_reg   <= shift_reg >> 1;
                        state       <= DATA;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        if (bit_idx == IDX_W'(WIDTH - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_serial_o <= parity_bit;
                            state       <= PARITY;
`else
                            tx_serial_o <= 1'b1;
                            state       <= STOP;
`endif
                        end else begin
                            bit_idx     <= bit_idx + 1'b1;
                            tx_serial_o <= shift_reg[0];
                            shift_reg   <= shift_reg >> 1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        tx_serial_o <= 1'b1;
                        state       <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (done_next) begin
                        tx_done_o <= 1'b1;
                    end
                    if (bit_tick) begin
                        tx_active_o <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: begin
                    tx_serial_o <= 1'b1;
                    tx_active_o <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule
